// File: rtl/pipearch_dma_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipearch_dma_read_arbiter
// Description : Round-robin arbiter sharing one DMA read engine between
//               NUM_CLIENTS requesters. It issues one command at a time and
//               routes the returned lines to the owning client.
//               Optional macro PIPEARCH_DMA_ARB_LENCHECK_EN enables a sticky
//               returned-line-count check (len_error).
// Revision    : 1.0 - initial release
// ============================================================================
module pipearch_dma_read_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_WIDTH  = 42,
    parameter int DATA_WIDTH  = 512,
    parameter int CID_WIDTH   = $clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CLIENTS*32-1:0]     req_length,
    output logic                          dma_start,
    output logic [ADDR_WIDTH-1:0]         dma_addr,
    output logic [31:0]                   dma_length,
    input  logic                          dma_done,
    input  logic                          dma_rvalid,
    input  logic [DATA_WIDTH-1:0]         dma_rdata,
    output logic [NUM_CLIENTS-1:0]        client_rvalid,
    output logic [DATA_WIDTH-1:0]         client_rdata,
    output logic [NUM_CLIENTS-1:0]        client_done,
    output logic [CID_WIDTH-1:0]          owner,
    output logic                          busy,
    output logic                          len_error
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE = 2'd1;
    localparam logic [1:0]  c_ST_BUSY  = 2'd2;
    localparam logic [1:0]  c_ST_DONE  = 2'd3;
    localparam logic [31:0] c_CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [NUM_CLIENTS-1:0] c_ONE = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CID_WIDTH-1:0]   r_rr_ptr;
    logic [CID_WIDTH-1:0]   r_owner;
    logic [CID_WIDTH-1:0]   w_winner;
    logic [CID_WIDTH-1:0]   w_rr_nxt;
    logic                   w_found;
    logic                   w_accept;
    logic                   w_beat;
    logic [NUM_CLIENTS-1:0] w_winner_oh;
    logic [NUM_CLIENTS-1:0] w_owner_oh;
    logic [ADDR_WIDTH-1:0]  r_dma_addr;
    logic [31:0]            r_dma_length;
    logic [31:0]            r_line_cnt;
    logic [31:0]            w_line_cnt_inc;
    logic [NUM_CLIENTS-1:0] r_client_rvalid;
    logic [DATA_WIDTH-1:0]  r_client_rdata;
    logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_CLIENTS];
    logic [31:0]            w_len_arr  [NUM_CLIENTS];

    // Index wrap for a value in [0, 2*NUM_CLIENTS-1].
    function automatic logic [CID_WIDTH-1:0] f_wrap_idx(input int v);
        int t;
        t = (v >= NUM_CLIENTS) ? (v - NUM_CLIENTS) : v;
        return CID_WIDTH'(t);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign w_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len_arr[gi]  = req_length[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!w_found && req_valid[f_wrap_idx(int'(r_rr_ptr) + i)]) begin
                w_found  = 1'b1;
                w_winner = f_wrap_idx(int'(r_rr_ptr) + i);
            end
        end
    end

    assign w_winner_oh    = c_ONE << w_winner;
    assign w_owner_oh     = c_ONE << r_owner;
    assign w_rr_nxt       = f_wrap_idx(int'(r_owner) + 1);
    assign w_line_cnt_inc = (r_line_cnt == c_CNT_MAX) ? r_line_cnt : r_line_cnt + 32'd1;
    assign w_accept       = (r_state == c_ST_IDLE) && w_found;
    assign w_beat         = (r_state == c_ST_BUSY) && dma_rvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        dma_start   = 1'b0;
        client_done = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    req_ready   = w_winner_oh;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                dma_start   = 1'b1;
                w_state_nxt = c_ST_BUSY;
            end
            c_ST_BUSY: begin
                if (dma_done) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                client_done = w_owner_oh;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr        <= '0;
            r_owner         <= '0;
            r_dma_addr      <= '0;
            r_dma_length    <= '0;
            r_line_cnt      <= '0;
            r_client_rvalid <= '0;
            r_client_rdata  <= '0;
        end else begin
            r_client_rvalid <= w_beat ? w_owner_oh : '0;
            if (w_beat) begin
                r_client_rdata <= dma_rdata;
                r_line_cnt     <= w_line_cnt_inc;
            end
            if (w_accept) begin
                r_dma_addr   <= w_addr_arr[w_winner];
                r_dma_length <= w_len_arr[w_winner];
                r_owner      <= w_winner;
                r_line_cnt   <= '0;
            end
            if (r_state == c_ST_DONE) begin
                r_rr_ptr <= w_rr_nxt;
            end
        end
    end

`ifdef PIPEARCH_DMA_ARB_LENCHECK_EN
    logic        r_len_error;
    logic [31:0] w_line_cnt_nxt;

    // A line arriving with dma_done still counts toward the total.
    assign w_line_cnt_nxt = dma_rvalid ? w_line_cnt_inc : r_line_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_error <= 1'b0;
        end else if ((r_state == c_ST_BUSY) && dma_done && (w_line_cnt_nxt != r_dma_length)) begin
            r_len_error <= 1'b1;
        end
    end

    assign len_error = r_len_error;
`else
    logic w_unused_line_cnt;
    assign w_unused_line_cnt = ^r_line_cnt;
    assign len_error         = 1'b0;
`endif

    assign dma_addr      = r_dma_addr;
    assign dma_length    = r_dma_length;
    assign client_rvalid = r_client_rvalid;
    assign client_rdata  = r_client_rdata;
    assign owner         = r_owner;
    assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/pipearch_dma_read_arbiter.md
# pipearch_dma_read_arbiter

Round-robin arbiter that shares one DMA read engine between `NUM_CLIENTS` requesters. It accepts one read command at a time (line address and line count), issues it to the engine as a single-cycle start pulse, and routes returned cache lines back to the owning client. It signals per-client completion and only then grants the next command. It sits between the per-PE load units and the single DMA read engine on the memory channel.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 42: cache-line address width.
- `DATA_WIDTH`, 512: cache-line width.
- `CID_WIDTH`, `$clog2(NUM_CLIENTS)`: width of the owner ID.

Ports:
- `clk`  in  1  single clock. Reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_CLIENTS  per-client command valid.
- `req_ready`  out  NUM_CLIENTS  one-hot accept.
- `req_addr`  in  NUM_CLIENTS×ADDR_WIDTH  start line address per client.
- `req_length`  in  NUM_CLIENTS×32  line count per client.
- `dma_start`  out  1  start pulse to the engine.
- `dma_addr`  out  ADDR_WIDTH  latched address.
- `dma_length`  out  32  latched length.
- `dma_done`  in  1  engine completion pulse.
- `dma_rvalid`  in  1  engine line valid.
- `dma_rdata`  in  DATA_WIDTH  engine line data.
- `client_rvalid`  out  NUM_CLIENTS  one-hot line valid to the owner.
- `client_rdata`  out  DATA_WIDTH  shared data bus.
- `client_done`  out  NUM_CLIENTS  one-hot completion pulse.
- `owner`  out  CID_WIDTH  ID of the current grant holder.
- `busy`  out  1  high in every state except IDLE.
- `len_error`  out  1  sticky length-mismatch flag (see Configuration).

## Operation
States: IDLE, ISSUE, BUSY, DONE.

IDLE:
- Winner = first client with `req_valid` set, scanning from `rr_ptr` upward, modulo NUM_CLIENTS.
- `req_ready[winner]` is driven combinationally in the same cycle.
- On that cycle, latch `req_addr`/`req_length` into `dma_addr`/`dma_length`, set `owner` = winner, clear `line_cnt`, go to ISSUE.
- No `req_valid`: stay in IDLE.

ISSUE:
- `dma_start` = 1 for exactly this cycle; go to BUSY.

BUSY:
- Each `dma_rvalid` sets `client_rvalid[owner]` and `client_rdata` = `dma_rdata` on the next cycle.
- `line_cnt` increments on each `dma_rvalid`. It is 32 bits and saturates at 0xFFFFFFFF.
- `dma_done` sampled high: go to DONE.

DONE:
- `client_done[owner]` = 1 for this cycle.
- `rr_ptr` = (owner+1) mod NUM_CLIENTS.
- Go to IDLE.

Boundary rules:
- `req_ready` is 0 in every state except IDLE. Requests held during BUSY wait and are never dropped.
- `dma_rvalid` and `dma_done` are ignored outside BUSY.
- A `dma_rvalid` in the same cycle as `dma_done` is still forwarded.
- Zero-length command: issued normally; completes when the engine returns `dma_done`.
- If the same client is the only requester, it is re-granted after every DONE.

## Timing
- Reset values: `req_ready`, `dma_start`, `client_rvalid`, `client_done`, `busy`, `len_error`, `owner`, `dma_addr`, `dma_length` and `client_rdata` are all 0. `rr_ptr` = 0. State = IDLE.
- Reset mid-operation aborts immediately to IDLE. No `client_done` is emitted. The engine shares the same reset.
- Accept to `dma_start`: 1 cycle (accept in cycle T, start in T+1).
- Data path latency: 1 cycle.
- `dma_done` to `client_done`: 1 cycle.
- DONE to next possible accept: 1 cycle. Minimum spacing between two grants is 4 cycles plus engine time.

## Configuration
- `PIPEARCH_DMA_ARB_LENCHECK_EN` defined:
  - On entry to DONE, compare `line_cnt` with `dma_length`.
  - On mismatch, set `len_error` = 1. It is sticky until reset.
- Not defined: `len_error` is tied to 0 and the comparison logic is not built. `line_cnt` is still kept.

## Test plan
- Single request: client 1 requests addr 0x100, length 8 → `req_ready[1]` in the accept cycle, `dma_start` one cycle later with `dma_addr` = 0x100, 8 lines on `client_rvalid[1]` only, `client_done[1]` one cycle after `dma_done`.
- All 4 clients hold `req_valid` continuously, lengths 2 → grant order 0,1,2,3,0, with no grant while `busy`.
- Zero length: client 2, length 0, engine returns `dma_done` with no data → `client_done[2]` pulses and no `client_rvalid` is asserted.
- Stray data: `dma_rvalid` asserted in IDLE → no `client_rvalid`, `line_cnt` unchanged.
- Reset in BUSY after 3 of 8 lines → next cycle all outputs are 0, state is IDLE, no `client_done`; the next grant goes to client 0.
- With `PIPEARCH_DMA_ARB_LENCHECK_EN`: length 4, engine returns 3 lines then `dma_done` → `len_error` = 1 from the DONE cycle onward and stays high. Without the macro, `len_error` stays 0.
